// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: widths, reset PC,
// fetch state encoding and a small alignment helper.
package pc_fetch_ctrl_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam int              INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side buses: instruction-memory request/response and the decode output.
// master = fetch controller, slave = memory + decode.
interface pc_fetch_ctrl_if
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = pc_fetch_ctrl_pkg::XLEN
) ();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

endinterface

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// Program counter register: a redirect load wins over the sequential increment.
module pc_fetch_ctrl_pc_reg
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = pc_fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_ctrl_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: one outstanding instruction fetch at a time, redirect
// handling with response discard, and a held output register toward decode.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = pc_fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_ctrl_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_target,
    pc_fetch_ctrl_if.master        bus,
    output logic                   misalign_err,
    output logic [XLEN-1:0]        err_addr
);

    fetch_state_e    state_q;
    logic            discard_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_instr_q;
    logic [XLEN-1:0] if_pc_q;
    logic            misalign_err_q;
    logic [XLEN-1:0] err_addr_q;
    logic [XLEN-1:0] pc;

    logic redir_aligned;
    logic redir_take;
    logic redir_bad;
    logic rsp_accept;

    assign redir_aligned = is_aligned(redirect_target[1:0]);
    assign redir_take    = redirect_valid && redir_aligned && (state_q != BOOT);
    assign redir_bad     = redirect_valid && !redir_aligned;
    assign rsp_accept    = (state_q == WAIT) && bus.imem_rsp_valid && !discard_q;

    pc_fetch_ctrl_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (redir_take),
        .load_val_i (redirect_target),
        .inc_i      (rsp_accept),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            discard_q      <= 1'b0;
            if_valid_q     <= 1'b0;
            if_instr_q     <= '0;
            if_pc_q        <= '0;
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            misalign_err_q <= redir_bad;
            if (redir_bad) begin
                err_addr_q <= redirect_target;
            end
            case (state_q)
                BOOT: state_q <= REQ;
                REQ: begin
                    // A redirect racing the handshake lets the old fetch finish, then drops its word.
                    if (bus.imem_req_ready) begin
                        state_q   <= WAIT;
                        discard_q <= redir_take;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (discard_q || redir_take) begin
                            discard_q <= 1'b0;
                            state_q   <= REQ;
                        end else begin
                            if_instr_q <= bus.imem_rsp_data;
                            if_pc_q    <= pc;
                            if_valid_q <= 1'b1;
                            state_q    <= OUT;
                        end
                    end else if (redir_take) begin
                        discard_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (redir_take || bus.if_ready) begin
                        if_valid_q <= 1'b0;
                        state_q    <= REQ;
                    end
                end
            endcase
        end
    end

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
    assign misalign_err       = misalign_err_q;
    assign err_addr           = err_addr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl with a small instruction-memory responder
// whose response delay is selectable per scenario.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        misalign_err;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;
    int mem_delay = 0;

    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    pc_fetch_ctrl_if bus_if ();

    pc_fetch_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (bus_if),
        .misalign_err    (misalign_err),
        .err_addr        (err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    // Instruction memory: responds mem_delay cycles after the accepted request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_if.imem_rsp_valid <= 1'b0;
            bus_if.imem_rsp_data  <= 32'h0;
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
            mem_addr <= 32'h0;
        end else begin
            bus_if.imem_rsp_valid <= 1'b0;
            if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                if (mem_delay == 0) begin
                    bus_if.imem_rsp_valid <= 1'b1;
                    bus_if.imem_rsp_data  <= instr_of(bus_if.imem_req_addr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_delay - 1;
                    mem_addr <= bus_if.imem_req_addr;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 0) begin
                    bus_if.imem_rsp_valid <= 1'b1;
                    bus_if.imem_rsp_data  <= instr_of(mem_addr);
                    mem_busy <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ifv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.if_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.if_ready = 1'b1;
        repeat (3) tick();
        checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus_if.imem_req_valid); end
        checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b want 0", bus_if.if_valid); end
        checks++; if ({bus_if.if_pc, bus_if.if_instr, err_addr, misalign_err} !== 97'h0) begin errors++; $display("FAIL rst_regs: pc %h instr %h err_addr %h err %b want all 0", bus_if.if_pc, bus_if.if_instr, err_addr, misalign_err); end
        rst_n = 1'b1;
        checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_cycle1_req: got %b want 0", bus_if.imem_req_valid); end
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h0) begin errors++; $display("FAIL boot_cycle2_req: valid %b addr %h want 1 / 00000000", bus_if.imem_req_valid, bus_if.imem_req_addr); end
        tick();
        tick();
        checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'h0 || bus_if.if_instr !== 32'h1357_0013) begin errors++; $display("FAIL boot_first_instr: valid %b pc %h instr %h want 1 / 00000000 / 13570013", bus_if.if_valid, bus_if.if_pc, bus_if.if_instr); end
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h4 || bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL boot_second_req: valid %b addr %h if_valid %b want 1 / 00000004 / 0", bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.if_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bus_if.if_ready = 1'b0;
        wait_ifv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: if_valid never rose"); end
        checks++; if (bus_if.if_pc !== 32'h4 || bus_if.if_instr !== 32'h1357_0017) begin errors++; $display("FAIL bp_first: pc %h instr %h want 00000004 / 13570017", bus_if.if_pc, bus_if.if_instr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'h4 || bus_if.if_instr !== 32'h1357_0017) begin errors++; $display("FAIL bp_hold[%0d]: valid %b pc %h instr %h want 1 / 00000004 / 13570017", i, bus_if.if_valid, bus_if.if_pc, bus_if.if_instr); end
            checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_req[%0d]: got %b want 0", i, bus_if.imem_req_valid); end
        end
        bus_if.if_ready = 1'b1;
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h8 || bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid %b addr %h if_valid %b want 1 / 00000008 / 0", bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.if_valid); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rw_timeout_req: no request"); end
        redirect_valid = 1'b1; redirect_target = 32'h10; bus_if.imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; bus_if.imem_req_ready = 1'b1; mem_delay = 2;
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h10) begin errors++; $display("FAIL rw_req_redirect: valid %b addr %h want 1 / 00000010", bus_if.imem_req_valid, bus_if.imem_req_addr); end
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b0 || bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rw_in_wait: req %b if_valid %b want 0 / 0", bus_if.imem_req_valid, bus_if.if_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (bus_if.imem_req_valid !== 1'b0 || bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rw_after_redirect: req %b if_valid %b want 0 / 0", bus_if.imem_req_valid, bus_if.if_valid); end
        tick();
        checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rw_rsp_cycle: if_valid %b want 0", bus_if.if_valid); end
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h100 || bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rw_discard: req %b addr %h if_valid %b want 1 / 00000100 / 0", bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.if_valid); end
        mem_delay = 0;
        wait_ifv(ok);
        checks++; if (!ok || bus_if.if_pc !== 32'h100 || bus_if.if_instr !== 32'h1357_0113) begin errors++; $display("FAIL rw_new_instr: ok %b pc %h instr %h want 1 / 00000100 / 13570113", ok, bus_if.if_pc, bus_if.if_instr); end
    endtask

    task automatic test_redirect_out();
        bit ok;
        wait_req(ok);
        redirect_valid = 1'b1; redirect_target = 32'h20; bus_if.imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; bus_if.imem_req_ready = 1'b1; bus_if.if_ready = 1'b0;
        checks++; if (!ok || bus_if.imem_req_addr !== 32'h20) begin errors++; $display("FAIL ro_setup: ok %b addr %h want 1 / 00000020", ok, bus_if.imem_req_addr); end
        wait_ifv(ok);
        checks++; if (!ok || bus_if.if_pc !== 32'h20) begin errors++; $display("FAIL ro_if_pc: ok %b pc %h want 1 / 00000020", ok, bus_if.if_pc); end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (bus_if.if_valid !== 1'b0 || bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h40) begin errors++; $display("FAIL ro_flush: if_valid %b req %b addr %h want 0 / 1 / 00000040", bus_if.if_valid, bus_if.imem_req_valid, bus_if.imem_req_addr); end
        bus_if.if_ready = 1'b1;
    endtask

    task automatic test_misalign();
        bit ok;
        wait_req(ok);
        redirect_valid = 1'b1; redirect_target = 32'h200; bus_if.imem_req_ready = 1'b0;
        tick();
        checks++; if (!ok || bus_if.imem_req_addr !== 32'h200 || misalign_err !== 1'b0) begin errors++; $display("FAIL ma_setup: ok %b addr %h err %b want 1 / 00000200 / 0", ok, bus_if.imem_req_addr, misalign_err); end
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0; bus_if.imem_req_ready = 1'b1;
        checks++; if (misalign_err !== 1'b1 || err_addr !== 32'h102) begin errors++; $display("FAIL ma_pulse: err %b err_addr %h want 1 / 00000102", misalign_err, err_addr); end
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h200) begin errors++; $display("FAIL ma_pc_kept: req %b addr %h want 1 / 00000200", bus_if.imem_req_valid, bus_if.imem_req_addr); end
        tick();
        checks++; if (misalign_err !== 1'b0 || err_addr !== 32'h102) begin errors++; $display("FAIL ma_one_cycle: err %b err_addr %h want 0 / 00000102", misalign_err, err_addr); end
        wait_ifv(ok);
        checks++; if (!ok || bus_if.if_pc !== 32'h200) begin errors++; $display("FAIL ma_fetch: ok %b pc %h want 1 / 00000200", ok, bus_if.if_pc); end
        wait_req(ok);
        checks++; if (!ok || bus_if.imem_req_addr !== 32'h204) begin errors++; $display("FAIL ma_next: ok %b addr %h want 1 / 00000204", ok, bus_if.imem_req_addr); end
    endtask

    task automatic test_wrap_reset();
        bit ok;
        wait_req(ok);
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; bus_if.imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; bus_if.imem_req_ready = 1'b1;
        checks++; if (!ok || bus_if.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_top: ok %b addr %h want 1 / fffffffc", ok, bus_if.imem_req_addr); end
        wait_ifv(ok);
        checks++; if (!ok || bus_if.if_pc !== 32'hFFFF_FFFC || bus_if.if_instr !== 32'hECA8_FFEF) begin errors++; $display("FAIL wr_instr: ok %b pc %h instr %h want 1 / fffffffc / eca8ffef", ok, bus_if.if_pc, bus_if.if_instr); end
        wait_req(ok);
        checks++; if (!ok || bus_if.imem_req_addr !== 32'h0) begin errors++; $display("FAIL wr_wrap: ok %b addr %h want 1 / 00000000", ok, bus_if.imem_req_addr); end
        mem_delay = 3;
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_in_wait: req %b want 0", bus_if.imem_req_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus_if.if_pc, bus_if.if_instr, err_addr} !== 96'h0 || bus_if.if_valid !== 1'b0 || bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_async_wait: pc %h instr %h err_addr %h ifv %b req %b want 0s", bus_if.if_pc, bus_if.if_instr, err_addr, bus_if.if_valid, bus_if.imem_req_valid); end
        mem_delay = 0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_req_addr !== 32'h0) begin errors++; $display("FAIL wr_reset_pc: req %b addr %h want 1 / 00000000", bus_if.imem_req_valid, bus_if.imem_req_addr); end
        bus_if.imem_req_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_async_req: req %b want 0", bus_if.imem_req_valid); end
        tick();
        rst_n = 1'b1; bus_if.imem_req_ready = 1'b1; bus_if.if_ready = 1'b0;
        wait_ifv(ok);
        checks++; if (!ok || bus_if.if_pc !== 32'h0) begin errors++; $display("FAIL wr_refetch: ok %b pc %h want 1 / 00000000", ok, bus_if.if_pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL wr_async_ifv: if_valid %b want 0", bus_if.if_valid); end
        tick();
        rst_n = 1'b1; bus_if.if_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_out();
        test_misalign();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the program counter and drives instruction fetch for the single-cycle RISC-V core.
- Consumes the branch/jump target produced by the PC-plus-offset adder as a redirect.
- Issues one request at a time to instruction memory over a valid/ready request channel with a valid-only response channel.
- Presents each fetched instruction and its PC to decode through a valid/ready output register.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  new PC (pc_present + signed_offset from the branch adder).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  instruction word returned. Responses arrive in order; at most one is outstanding.
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  instruction available to decode.
- if_instr  out  XLEN  fetched instruction.
- if_pc  out  XLEN  PC of if_instr.
- if_ready  in  1  decode accepts instruction.
- misalign_err  out  1  one-cycle pulse: redirect target not 4-byte aligned.
- err_addr  out  XLEN  last misaligned target.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - pc=RESET_PC; state=BOOT.
  - imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, err_addr=0, discard=0.
- States: BOOT, REQ, WAIT, OUT.
- BOOT: exactly one cycle after rst_n release, then REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_addr is stable while valid and not ready, unless a redirect occurs.
  - On imem_req_ready, go to WAIT.
- WAIT:
  - On imem_rsp_valid with discard=1: drop the word, clear discard, go to REQ.
  - On imem_rsp_valid with discard=0: if_instr=rsp_data, if_pc=pc, if_valid=1, pc=pc+4, go to OUT.
- OUT:
  - if_valid, if_instr and if_pc are held stable until if_ready.
  - On if_valid & if_ready: if_valid=0 next cycle, go to REQ.
- Latency: zero-wait memory gives request -> if_valid in 2 cycles; throughput is 1 instruction per 3 cycles (no overlap by design).
- Arithmetic:
  - pc+4 is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
  - pc[1:0] is always 0.
- Aligned redirect (redirect_target[1:0]==0):
  - Accepted in any state except BOOT, where it is ignored.
  - Takes priority over the pc+4 update; pc=redirect_target.
  - In REQ without req_ready: the next-cycle request uses the new pc.
  - In REQ with req_ready the same cycle: the old-address handshake completes; go to WAIT with discard=1.
  - In WAIT without rsp_valid: discard=1.
  - In WAIT with rsp_valid the same cycle: drop the word, go to REQ.
  - In OUT: if_valid cleared next cycle (flush, regardless of if_ready), go to REQ.
- Misaligned redirect: pc and state unchanged; misalign_err=1 for one cycle; err_addr=redirect_target.
- Reset mid-operation: all state returns to reset values immediately. A response in flight after rst_n release is not expected; memory is reset by the same rst_n.

Decomposition:
- Shared core package holds:
  - XLEN;
  - RESET_PC default;
  - the fetch state encoding (BOOT=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3);
  - INSTR_BYTES=4.
- One sub-module is natural: pc_reg (async active-low reset register with a load/increment mux, redirect priority over increment).

Test Plan:
- Reset and boot: hold rst_n=0 for 3 cycles, release; memory always ready with zero wait. Required:
  - imem_req_addr=0x0 on cycle 2;
  - if_valid with if_pc=0x0;
  - next request at 0x4.
- Backpressure: hold if_ready=0 for 5 cycles while if_valid=1. Required:
  - if_instr and if_pc stable;
  - no new request;
  - after if_ready=1, next addr = if_pc+4.
- Redirect in WAIT: request 0x10 outstanding, redirect_target=0x100. Required:
  - the 0x10 response is discarded (if_valid stays 0);
  - next request is 0x100;
  - if_pc=0x100.
- Redirect in OUT: if_valid=1 at pc 0x20, redirect 0x40, if_ready=0. Required: if_valid=0 next cycle, next request 0x40.
- Misaligned redirect 0x102 while PC at 0x200. Required:
  - misalign_err high for 1 cycle;
  - err_addr=0x102;
  - fetch continues at 0x200/0x204.
- Wrap and async reset: redirect to 0xFFFF_FFFC, then assert rst_n mid-WAIT. Required:
  - request after 0xFFFF_FFFC is 0x0;
  - async assert clears if_valid and imem_req_valid before the next clk edge;
  - pc=RESET_PC.
